// File: rtl/param_commit_pkg.sv
// Shared constants, slot map, reset defaults and FSM encoding for the
// host-parameter commit sequencer.
package param_commit_pkg;

  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned DW        = 32;

  localparam int unsigned SLOT_PPS_IA    = 1;
  localparam int unsigned SLOT_PPS_II    = 2;
  localparam int unsigned SLOT_BIAS      = 3;
  localparam int unsigned SLOT_GAMMA_DYN = 4;
  localparam int unsigned SLOT_GAMMA_STA = 5;
  localparam int unsigned SLOT_GAIN      = 6;
  localparam int unsigned SLOT_DELAY_CNT = 7;
  localparam int unsigned SLOT_BDAMP_F   = 13;
  localparam int unsigned SLOT_BDAMP_2   = 14;
  localparam int unsigned SLOT_BDAMP_1   = 15;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StCommit = 2'd2
  } state_e;

  function automatic logic [DW-1:0] slot_default(input int unsigned idx);
    logic [DW-1:0] val;
    val = '0;
    case (idx)
      SLOT_PPS_IA:    val = 32'h3F66_6666;
      SLOT_PPS_II:    val = 32'h3F66_6666;
      SLOT_GAMMA_DYN: val = 32'h42A0_0000;
      SLOT_GAMMA_STA: val = 32'h42A0_0000;
      SLOT_GAIN:      val = 32'h0000_0001;
      SLOT_BDAMP_F:   val = 32'h3C58_44D0;
      SLOT_BDAMP_2:   val = 32'h3D14_4674;
      SLOT_BDAMP_1:   val = 32'h3E71_4120;
      default:        val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/param_slot.sv
// One parameter slot: shadow (staged) value, active (committed) value and
// dirty flag.
module param_slot #(
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  DEFAULT = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          capture,
  input  logic          commit,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] active,
  output logic          dirty
);

  logic [DW-1:0] shadow;

  // A capture in the commit cycle wins the dirty flag; active still takes
  // the pre-capture shadow because of non-blocking semantics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= DEFAULT;
      active <= DEFAULT;
      dirty  <= 1'b0;
    end else begin
      if (capture) shadow <= wdata;
      if (commit && dirty) active <= shadow;
      if (capture) dirty <= 1'b1;
      else if (commit) dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/param_commit_sequencer.sv
// Stages triggered host writes into shadow slots and applies all pending
// values atomically on the next unheld simulation tick.
module param_commit_sequencer
  import param_commit_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = param_commit_pkg::NUM_SLOTS,
  parameter int unsigned DW        = param_commit_pkg::DW
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SLOTS-1:0]    trig,
  input  logic [15:0]             data_lo,
  input  logic [15:0]             data_hi,
  input  logic                    sim_tick,
  input  logic                    hold,
  output logic [NUM_SLOTS*DW-1:0] param_flat,
  output logic [NUM_SLOTS-1:0]    dirty,
  output logic                    committed,
  output logic [15:0]             commit_cnt,
  output logic [15:0]             overwrite_cnt
);

  state_e               state;
  logic [NUM_SLOTS-1:0] cap;
  logic [DW-1:0]        wdata;
  logic                 capture_any;
  logic                 overwrite;
  logic                 commit;

  // Slot 0 is reserved: mask its trigger out before anything sees it.
  assign cap         = trig & {{(NUM_SLOTS-1){1'b1}}, 1'b0};
  assign wdata       = DW'({data_hi, data_lo});
  assign capture_any = |cap;
  assign overwrite   = |(cap & dirty);
  assign commit      = (state == StCommit);

  assign param_flat[DW-1:0] = '0;
  assign dirty[0]           = 1'b0;

  for (genvar i = 1; i < NUM_SLOTS; i++) begin : g_slot
    param_slot #(
      .DW      (DW),
      .DEFAULT (slot_default(i))
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .capture (cap[i]),
      .commit  (commit),
      .wdata   (wdata),
      .active  (param_flat[i*DW +: DW]),
      .dirty   (dirty[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= StIdle;
      committed     <= 1'b0;
      commit_cnt    <= '0;
      overwrite_cnt <= '0;
    end else begin
      committed <= commit;
      if (commit) commit_cnt <= commit_cnt + 16'd1;
      if (overwrite && overwrite_cnt != 16'hFFFF) overwrite_cnt <= overwrite_cnt + 16'd1;
      case (state)
        StIdle:   if (capture_any) state <= StArmed;
        StArmed:  if (sim_tick && !hold) state <= StCommit;
        StCommit: state <= capture_any ? StArmed : StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_param_commit_sequencer.sv
// Directed self-checking bench for param_commit_sequencer.
module tb_param_commit_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  trig;
  logic [15:0]  data_lo;
  logic [15:0]  data_hi;
  logic         sim_tick;
  logic         hold;
  logic [511:0] param_flat;
  logic [15:0]  dirty;
  logic         committed;
  logic [15:0]  commit_cnt;
  logic [15:0]  overwrite_cnt;

  int total = 0;
  int bad   = 0;

  param_commit_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .trig          (trig),
    .data_lo       (data_lo),
    .data_hi       (data_hi),
    .sim_tick      (sim_tick),
    .hold          (hold),
    .param_flat    (param_flat),
    .dirty         (dirty),
    .committed     (committed),
    .commit_cnt    (commit_cnt),
    .overwrite_cnt (overwrite_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slot(input int i);
    return param_flat[i*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    trig     = '0;
    data_lo  = '0;
    data_hi  = '0;
    sim_tick = 1'b0;
    hold     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic write(input logic [15:0] mask, input logic [31:0] word);
    trig    = mask;
    data_hi = word[31:16];
    data_lo = word[15:0];
    step();
    trig = '0;
  endtask

  // Tick pulse plus the following edge: commit results are visible afterwards.
  task automatic tick_and_commit();
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (slot(4) !== 32'h42A0_0000) begin bad++;
      $display("FAIL reset_slot4 got=%h exp=%h", slot(4), 32'h42A0_0000); end
    total++; if (slot(15) !== 32'h3E71_4120) begin bad++;
      $display("FAIL reset_slot15 got=%h exp=%h", slot(15), 32'h3E71_4120); end
    total++; if (slot(1) !== 32'h3F66_6666) begin bad++;
      $display("FAIL reset_slot1 got=%h exp=%h", slot(1), 32'h3F66_6666); end
    total++; if (slot(6) !== 32'h1) begin bad++;
      $display("FAIL reset_slot6 got=%h exp=%h", slot(6), 32'h1); end
    total++; if (dirty !== 16'h0) begin bad++;
      $display("FAIL reset_dirty got=%h exp=%h", dirty, 16'h0); end
    total++; if (commit_cnt !== 16'h0 || overwrite_cnt !== 16'h0 || committed !== 1'b0) begin
      bad++; $display("FAIL reset_counters got=%h/%h/%b exp=0/0/0",
                      commit_cnt, overwrite_cnt, committed); end
  endtask

  task automatic test_single_write();
    do_reset();
    write(16'h0008, 32'h4120_0000);
    total++; if (dirty !== 16'h0008) begin bad++;
      $display("FAIL single_dirty got=%h exp=%h", dirty, 16'h0008); end
    total++; if (slot(3) !== 32'h0) begin bad++;
      $display("FAIL single_pre got=%h exp=%h", slot(3), 32'h0); end
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    total++; if (slot(3) !== 32'h0 || committed !== 1'b0) begin bad++;
      $display("FAIL single_mid got=%h/%b exp=0/0", slot(3), committed); end
    step();
    total++; if (slot(3) !== 32'h4120_0000) begin bad++;
      $display("FAIL single_commit got=%h exp=%h", slot(3), 32'h4120_0000); end
    total++; if (committed !== 1'b1 || commit_cnt !== 16'd1 || dirty !== 16'h0) begin bad++;
      $display("FAIL single_flags got=%b/%h/%h exp=1/0001/0000", committed, commit_cnt, dirty); end
    step();
    total++; if (committed !== 1'b0 || commit_cnt !== 16'd1) begin bad++;
      $display("FAIL single_pulse got=%b/%h exp=0/0001", committed, commit_cnt); end
  endtask

  task automatic test_overwrite();
    do_reset();
    write(16'h6000, 32'hAAAA_1111);
    total++; if (dirty !== 16'h6000 || overwrite_cnt !== 16'd0) begin bad++;
      $display("FAIL ovw_first got=%h/%h exp=6000/0000", dirty, overwrite_cnt); end
    write(16'h2000, 32'hBBBB_2222);
    total++; if (overwrite_cnt !== 16'd1) begin bad++;
      $display("FAIL ovw_count got=%h exp=%h", overwrite_cnt, 16'd1); end
    tick_and_commit();
    total++; if (slot(13) !== 32'hBBBB_2222 || slot(14) !== 32'hAAAA_1111) begin bad++;
      $display("FAIL ovw_values got=%h/%h exp=bbbb2222/aaaa1111", slot(13), slot(14)); end
    total++; if (dirty !== 16'h0 || commit_cnt !== 16'd1) begin bad++;
      $display("FAIL ovw_after got=%h/%h exp=0000/0001", dirty, commit_cnt); end
    write(16'h6000, 32'h1);
    write(16'h6000, 32'h2);
    total++; if (overwrite_cnt !== 16'd2) begin bad++;
      $display("FAIL ovw_per_cycle got=%h exp=%h", overwrite_cnt, 16'd2); end
  endtask

  task automatic test_slot0_and_idle_tick();
    do_reset();
    write(16'h0001, 32'hDEAD_BEEF);
    total++; if (dirty !== 16'h0 || slot(0) !== 32'h0) begin bad++;
      $display("FAIL slot0_ignored got=%h/%h exp=0000/00000000", dirty, slot(0)); end
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    write(16'h0004, 32'h0000_0042);
    step();
    step();
    total++; if (commit_cnt !== 16'd0 || slot(2) !== 32'h3F66_6666 || dirty !== 16'h0004) begin
      bad++; $display("FAIL idle_tick got=%h/%h/%h exp=0000/3f666666/0004",
                      commit_cnt, slot(2), dirty); end
  endtask

  task automatic test_hold();
    do_reset();
    write(16'h0020, 32'h4000_0000);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick_and_commit();
      step();
    end
    total++; if (commit_cnt !== 16'd0 || slot(5) !== 32'h42A0_0000 || dirty !== 16'h0020) begin
      bad++; $display("FAIL hold_blocked got=%h/%h/%h exp=0000/42a00000/0020",
                      commit_cnt, slot(5), dirty); end
    hold = 1'b0;
    tick_and_commit();
    total++; if (commit_cnt !== 16'd1 || slot(5) !== 32'h4000_0000) begin bad++;
      $display("FAIL hold_release got=%h/%h exp=0001/40000000", commit_cnt, slot(5)); end
  endtask

  task automatic test_commit_capture();
    do_reset();
    write(16'h0080, 32'd100);
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    write(16'h0080, 32'd500);
    total++; if (slot(7) !== 32'd100 || dirty !== 16'h0080) begin bad++;
      $display("FAIL cc_first got=%h/%h exp=00000064/0080", slot(7), dirty); end
    total++; if (commit_cnt !== 16'd1 || committed !== 1'b1) begin bad++;
      $display("FAIL cc_count got=%h/%b exp=0001/1", commit_cnt, committed); end
    tick_and_commit();
    total++; if (slot(7) !== 32'd500 || dirty !== 16'h0 || commit_cnt !== 16'd2) begin bad++;
      $display("FAIL cc_second got=%h/%h/%h exp=000001f4/0000/0002", slot(7), dirty, commit_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write(16'h0040, 32'd5);
    reset_n = 1'b0;
    #2;
    total++; if (slot(6) !== 32'h1 || dirty !== 16'h0) begin bad++;
      $display("FAIL midrst_async got=%h/%h exp=00000001/0000", slot(6), dirty); end
    #2;
    reset_n = 1'b1;
    tick_and_commit();
    step();
    total++; if (slot(6) !== 32'h1 || commit_cnt !== 16'd0 || committed !== 1'b0) begin bad++;
      $display("FAIL midrst_tick got=%h/%h/%b exp=00000001/0000/0", slot(6), commit_cnt, committed); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overwrite();
    test_slot0_and_idle_tick();
    test_hold();
    test_commit_capture();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
